// File: rtl/counter_bank.sv
// Bank of COUNT down-counters sharing one opcode/select port: loads, decrements,
// a paired decrement+reload, a borrow chain and per-channel terminal-count strobes.
module counter_bank #(
    parameter int WIDTH = 16,
    parameter int COUNT = 4,
    localparam int SEL_WIDTH = (COUNT > 1) ? $clog2(COUNT) : 1
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic                   prog_enable,
    input  logic [2:0]             opcode,
    input  logic [SEL_WIDTH-1:0]   sel,
    input  logic [COUNT*WIDTH-1:0] const_data,
    input  logic [COUNT-1:0]       auto_reload,
    input  logic [7:0]             data_in,
    output logic [COUNT-1:0]       zero,
    output logic [COUNT-1:0]       tc_pulse,
    output logic [WIDTH-1:0]       count_out
);

    localparam logic [SEL_WIDTH:0] COUNT_W = (SEL_WIDTH + 1)'(COUNT);
    localparam logic [SEL_WIDTH:0] LAST_W  = (SEL_WIDTH + 1)'(COUNT - 1);

    localparam logic [2:0] OP_NOP      = 3'b000;
    localparam logic [2:0] OP_LD_CONST = 3'b001;
    localparam logic [2:0] OP_DEC      = 3'b010;
    localparam logic [2:0] OP_LD_DATA  = 3'b011;
    localparam logic [2:0] OP_LD_ALL   = 3'b100;
    localparam logic [2:0] OP_DEC_ALL  = 3'b101;
    localparam logic [2:0] OP_DEC_RLD  = 3'b110;
    localparam logic [2:0] OP_BORROW   = 3'b111;

    logic [WIDTH-1:0]     r_cnt [COUNT];
    logic [COUNT-1:0]     r_tc;

    logic                 w_sel_ok;
    logic                 w_sel_last;
    logic                 w_sel_zero;
    logic [SEL_WIDTH-1:0] w_nxt_sel;
    logic [WIDTH-1:0]     w_sel_val;
    logic [WIDTH-1:0]     w_next [COUNT];
    logic [COUNT-1:0]     w_tc_next;
    logic [COUNT-1:0]     w_is_sel;
    logic [COUNT-1:0]     w_is_nxt;
    logic [COUNT-1:0]     w_ld_c;
    logic [COUNT-1:0]     w_ld_d;
    logic [COUNT-1:0]     w_dec;

    // Saturating or reloading decrement; never wraps zero to all-ones.
    function automatic logic [WIDTH-1:0] f_dec(input logic [WIDTH-1:0] v,
                                               input logic             rl,
                                               input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] res;
        if (v != {WIDTH{1'b0}}) begin
            res = v - {{(WIDTH-1){1'b0}}, 1'b1};
        end else if (rl) begin
            res = c;
        end else begin
            res = v;
        end
        return res;
    endfunction

    assign w_sel_ok   = ({1'b0, sel} < COUNT_W);
    assign w_sel_last = ({1'b0, sel} == LAST_W);
    assign w_nxt_sel  = w_sel_last ? {SEL_WIDTH{1'b0}} : (sel + SEL_WIDTH'(1'b1));

    // One-hot decode of the selected channel and its successor.
    always_comb begin
        w_is_sel = {COUNT{1'b0}};
        w_is_nxt = {COUNT{1'b0}};
        for (int i = 0; i < COUNT; i++) begin
            w_is_sel[i] = w_sel_ok && (sel == SEL_WIDTH'(i));
            w_is_nxt[i] = w_sel_ok && (w_nxt_sel == SEL_WIDTH'(i));
        end
    end

    // Read mux of the selected channel; an out-of-range select reads zero.
    always_comb begin
        w_sel_val = {WIDTH{1'b0}};
        for (int i = 0; i < COUNT; i++) begin
            w_sel_val = w_sel_val | (r_cnt[i] & {WIDTH{w_is_sel[i]}});
        end
    end

    assign w_sel_zero = (w_sel_val == {WIDTH{1'b0}});
    assign count_out  = w_sel_val;
    assign tc_pulse   = r_tc;

    // Zero flags come straight from the registers.
    always_comb begin
        zero = {COUNT{1'b0}};
        for (int i = 0; i < COUNT; i++) begin
            zero[i] = (r_cnt[i] == {WIDTH{1'b0}});
        end
    end

    // Per-channel action decode and next-state; decrement outranks a load on the same channel.
    always_comb begin
        w_ld_c    = {COUNT{1'b0}};
        w_ld_d    = {COUNT{1'b0}};
        w_dec     = {COUNT{1'b0}};
        w_tc_next = {COUNT{1'b0}};
        for (int i = 0; i < COUNT; i++) begin
            w_next[i] = r_cnt[i];
            case (opcode)
                OP_NOP:      w_dec[i]  = 1'b0;
                OP_LD_CONST: w_ld_c[i] = w_is_sel[i];
                OP_DEC:      w_dec[i]  = w_is_sel[i];
                OP_LD_DATA:  w_ld_d[i] = w_is_sel[i];
                OP_LD_ALL:   w_ld_c[i] = 1'b1;
                OP_DEC_ALL:  w_dec[i]  = 1'b1;
                OP_DEC_RLD: begin
                    w_dec[i]  = w_is_sel[i];
                    w_ld_c[i] = w_is_nxt[i] && !w_is_sel[i];
                end
                OP_BORROW: begin
                    if (w_sel_zero) begin
                        w_ld_c[i] = w_is_sel[i];
                        w_dec[i]  = w_is_nxt[i] && !w_sel_last;
                    end else begin
                        w_dec[i]  = w_is_sel[i];
                    end
                end
                default:     w_dec[i]  = 1'b0;
            endcase
            if (w_dec[i]) begin
                w_next[i] = f_dec(r_cnt[i], auto_reload[i], const_data[i*WIDTH +: WIDTH]);
            end else if (w_ld_c[i]) begin
                w_next[i] = const_data[i*WIDTH +: WIDTH];
            end else if (w_ld_d[i]) begin
                w_next[i] = WIDTH'(data_in);
            end else begin
                w_next[i] = r_cnt[i];
            end
            w_tc_next[i] = w_dec[i] && (r_cnt[i] == {{(WIDTH-1){1'b0}}, 1'b1});
        end
    end

    // Channel and strobe registers; prog_enable is a synchronous clear over any opcode.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < COUNT; i++) begin
                r_cnt[i] <= {WIDTH{1'b0}};
            end
            r_tc <= {COUNT{1'b0}};
        end else if (prog_enable) begin
            for (int i = 0; i < COUNT; i++) begin
                r_cnt[i] <= {WIDTH{1'b0}};
            end
            r_tc <= {COUNT{1'b0}};
        end else begin
            for (int i = 0; i < COUNT; i++) begin
                r_cnt[i] <= w_next[i];
            end
            r_tc <= w_tc_next;
        end
    end

endmodule
